// File: rtl/mem_pool_pkg.sv
// Shared definitions for the memory-pool group arbiters (read and write side):
// one-hot grant encodings, requester indices and the fixed-priority helper.
package mem_pool_pkg;

    localparam int NUM_REQ  = 3;
    localparam int CONV_IDX = 0;
    localparam int MISC_IDX = 1;
    localparam int SAVE_IDX = 2;

    typedef logic [NUM_REQ-1:0] grant_t;

    localparam grant_t NONE_USE = 3'b000;
    localparam grant_t CONV_USE = 3'b001;
    localparam grant_t MISC_USE = 3'b010;
    localparam grant_t SAVE_USE = 3'b100;

    // conv > misc > save when no current owner keeps the grant
    function automatic grant_t fixed_priority(input grant_t valid);
        grant_t g;
        g = NONE_USE;
        if (valid[CONV_IDX])
            g = CONV_USE;
        else if (valid[MISC_IDX])
            g = MISC_USE;
        else if (valid[SAVE_IDX])
            g = SAVE_USE;
        return g;
    endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// One-hot owner tag shift register of configurable depth with synchronous
// clear; exposes the final-stage tag and an any-stage-occupied flag.
module arb_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] tag_in,
    output logic [WIDTH-1:0] tag_out,
    output logic             busy
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++)
                stage_r[i] <= '0;
        end else begin
            stage_r[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++)
                stage_r[i] <= stage_r[i-1];
        end
    end

    assign tag_out = stage_r[DEPTH-1];

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            busy = busy | (|stage_r[i]);
    end

endmodule

// File: rtl/read_arbiter.sv
// Read arbiter for one memory-pool group: sticky-owner grant among conv/misc/save,
// registered RAM request stage, and owner-tagged data return.
// Define READ_ARBITER_DATA_REG_EN to add one register stage on the return path.
module read_arbiter
    import mem_pool_pkg::*;
#(
    parameter int ROW_PARA    = 4,
    parameter int ADDR_WIDTH  = 48,
    parameter int DATA_WIDTH  = 256,
    parameter int RAM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_p,

    input  logic                  conv_read_valid_i,
    input  logic [ROW_PARA-1:0]   conv_read_bank_en_i,
    input  logic [ADDR_WIDTH-1:0] conv_read_addr_i,
    output logic                  conv_read_ready_o,
    output logic [DATA_WIDTH-1:0] conv_read_data_o,
    output logic                  conv_read_data_valid_o,

    input  logic                  misc_read_valid_i,
    input  logic [ROW_PARA-1:0]   misc_read_bank_en_i,
    input  logic [ADDR_WIDTH-1:0] misc_read_addr_i,
    output logic                  misc_read_ready_o,
    output logic [DATA_WIDTH-1:0] misc_read_data_o,
    output logic                  misc_read_data_valid_o,

    input  logic                  save_read_valid_i,
    input  logic [ROW_PARA-1:0]   save_read_bank_en_i,
    input  logic [ADDR_WIDTH-1:0] save_read_addr_i,
    output logic                  save_read_ready_o,
    output logic [DATA_WIDTH-1:0] save_read_data_o,
    output logic                  save_read_data_valid_o,

    output logic                  ram_read_en_o,
    output logic [ROW_PARA-1:0]   ram_read_bank_en_o,
    output logic [ADDR_WIDTH-1:0] ram_read_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_read_data_i,
    output logic                  read_busy_o
);

    // Handshake: a request is accepted in the cycle where its valid and ready are
    // both high; ready is the combinational grant bit and never depends on a later
    // cycle. Return beats carry no backpressure and must always be sunk.

    grant_t owner_r;
    grant_t grant;
    grant_t valid_vec;

    grant_t                req_tag_r;
    logic                  req_en_r;
    logic [ROW_PARA-1:0]   req_bank_r;
    logic [ADDR_WIDTH-1:0] req_addr_r;

    logic [ROW_PARA-1:0]   sel_bank;
    logic [ADDR_WIDTH-1:0] sel_addr;

    grant_t ret_tag;
    logic   pipe_busy;

    assign valid_vec = {save_read_valid_i, misc_read_valid_i, conv_read_valid_i};

    // Ownership register: the grant of the last cycle
    always_ff @(posedge clk) begin
        if (rst_p)
            owner_r <= NONE_USE;
        else
            owner_r <= grant;
    end

    // Next grant: current owner keeps it while still valid; no grant during reset
    always_comb begin
        grant = NONE_USE;
        if (!rst_p) begin
            case (owner_r)
                NONE_USE: grant = fixed_priority(valid_vec);
                CONV_USE: grant = valid_vec[CONV_IDX] ? CONV_USE : fixed_priority(valid_vec);
                MISC_USE: grant = valid_vec[MISC_IDX] ? MISC_USE : fixed_priority(valid_vec);
                SAVE_USE: grant = valid_vec[SAVE_IDX] ? SAVE_USE : fixed_priority(valid_vec);
                default:  grant = NONE_USE;
            endcase
        end
    end

    // Outputs of the grant machine
    always_comb begin
        conv_read_ready_o = grant[CONV_IDX];
        misc_read_ready_o = grant[MISC_IDX];
        save_read_ready_o = grant[SAVE_IDX];
    end

    always_comb begin
        sel_bank = '0;
        sel_addr = req_addr_r;
        case (grant)
            CONV_USE: begin
                sel_bank = conv_read_bank_en_i;
                sel_addr = conv_read_addr_i;
            end
            MISC_USE: begin
                sel_bank = misc_read_bank_en_i;
                sel_addr = misc_read_addr_i;
            end
            SAVE_USE: begin
                sel_bank = save_read_bank_en_i;
                sel_addr = save_read_addr_i;
            end
            default: begin
                sel_bank = '0;
                sel_addr = req_addr_r;
            end
        endcase
    end

    // Request stage: address holds its last value when idle
    always_ff @(posedge clk) begin
        if (rst_p) begin
            req_en_r   <= 1'b0;
            req_tag_r  <= NONE_USE;
            req_bank_r <= '0;
            req_addr_r <= '0;
        end else begin
            req_en_r   <= |grant;
            req_tag_r  <= grant;
            req_bank_r <= sel_bank;
            req_addr_r <= sel_addr;
        end
    end

    assign ram_read_en_o      = req_en_r;
    assign ram_read_bank_en_o = req_bank_r;
    assign ram_read_addr_o    = req_addr_r;

    // Tag enters aligned with the RAM strobe and exits when RAM data is valid
    arb_tag_pipe #(
        .DEPTH (RAM_LATENCY),
        .WIDTH (NUM_REQ)
    ) u_tag_pipe (
        .clk     (clk),
        .clear   (rst_p),
        .tag_in  (req_tag_r),
        .tag_out (ret_tag),
        .busy    (pipe_busy)
    );

`ifdef READ_ARBITER_DATA_REG_EN
    logic [DATA_WIDTH-1:0] ret_data_r;
    grant_t                ret_valid_r;

    always_ff @(posedge clk) begin
        if (rst_p) begin
            ret_data_r  <= '0;
            ret_valid_r <= NONE_USE;
        end else begin
            ret_data_r  <= ram_read_data_i;
            ret_valid_r <= ret_tag;
        end
    end

    assign conv_read_data_o       = ret_data_r;
    assign misc_read_data_o       = ret_data_r;
    assign save_read_data_o       = ret_data_r;
    assign conv_read_data_valid_o = ret_valid_r[CONV_IDX];
    assign misc_read_data_valid_o = ret_valid_r[MISC_IDX];
    assign save_read_data_valid_o = ret_valid_r[SAVE_IDX];
    assign read_busy_o            = req_en_r | pipe_busy | (|ret_valid_r);
`else
    assign conv_read_data_o       = ram_read_data_i;
    assign misc_read_data_o       = ram_read_data_i;
    assign save_read_data_o       = ram_read_data_i;
    assign conv_read_data_valid_o = ret_tag[CONV_IDX];
    assign misc_read_data_valid_o = ret_tag[MISC_IDX];
    assign save_read_data_valid_o = ret_tag[SAVE_IDX];
    assign read_busy_o            = req_en_r | pipe_busy;
`endif

endmodule
